// File: rtl/alu_rs_sched_pkg.sv
// Shared types and constants for the ALU reservation-station scheduler.
// The opcode values are the common encoding used by decoder and ALU.
package alu_rs_sched_pkg;

  localparam int RS_SIZE_DEF   = 8;
  localparam int ROB_IDX_W_DEF = 4;
  localparam int OPT_W_DEF     = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0]              WORD_TP;
  typedef logic [ROB_IDX_W_DEF-1:0] ROB_IDX_TP;

  localparam WORD_TP ZERO_WORD = '0;

  typedef enum logic [OPT_W_DEF-1:0] {
    OPT_NONE = 6'd0,
    OPT_ADD  = 6'd1,
    OPT_SUB  = 6'd2,
    OPT_ADDI = 6'd3,
    OPT_AND  = 6'd4,
    OPT_OR   = 6'd5,
    OPT_XOR  = 6'd6,
    OPT_BEQ  = 6'd7,
    OPT_BNE  = 6'd8,
    OPT_BLT  = 6'd9
  } opt_e;

endpackage

// File: rtl/alu_rs_sched_pick.sv
// Find-first-set over a bit vector: lowest set index plus a found flag.
module rs_pick #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Scanning high-to-low lets the lowest set bit overwrite the others.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_sched.sv
// Reservation station feeding the integer ALU: holds dispatched uops until
// both operands arrive via the CDB, then issues one per cycle to the ALU.
module alu_rs_sched
  import alu_rs_sched_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int OPT_W     = OPT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rob_flush,
  input  logic                 disp_en,
  input  logic [OPT_W-1:0]     disp_opt,
  input  logic [31:0]          disp_val1,
  input  logic [31:0]          disp_val2,
  input  logic                 disp_q1_busy,
  input  logic                 disp_q2_busy,
  input  logic [ROB_IDX_W-1:0] disp_q1,
  input  logic [ROB_IDX_W-1:0] disp_q2,
  input  logic [31:0]          disp_imm,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  output logic                 rs_full,
  input  logic                 cdb_alu_valid,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_src,
  input  logic [ROB_IDX_W-1:0] cdb_lsb_src,
  input  logic [31:0]          cdb_alu_val,
  input  logic [31:0]          cdb_lsb_val,
  output logic                 alu_en,
  output logic [OPT_W-1:0]     alu_opt,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [ROB_IDX_W-1:0] alu_rob_idx
);

  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   r_valid;
  logic [RS_SIZE-1:0]   r_q1b;
  logic [RS_SIZE-1:0]   r_q2b;
  logic [OPT_W-1:0]     r_opt [RS_SIZE];
  WORD_TP               r_v1  [RS_SIZE];
  WORD_TP               r_v2  [RS_SIZE];
  WORD_TP               r_imm [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_q1  [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_q2  [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_rob [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic [IW-1:0]      w_free_idx;
  logic               w_free_found;
  logic [IW-1:0]      w_rdy_idx;
  logic               w_rdy_found;
  logic               w_dispatch;
  logic               w_d_q1b;
  logic               w_d_q2b;
  WORD_TP             w_d_v1;
  WORD_TP             w_d_v2;

  // Readiness uses start-of-cycle busy bits, so a same-cycle wakeup waits a cycle.
  assign w_ready    = r_valid & ~r_q1b & ~r_q2b;
  assign rs_full    = &r_valid;
  assign w_dispatch = disp_en & w_free_found & ~rob_flush & rdy;

  rs_pick #(.N(RS_SIZE)) u_pick_free (
    .i_vec   (~r_valid),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_pick #(.N(RS_SIZE)) u_pick_ready (
    .i_vec   (w_ready),
    .o_idx   (w_rdy_idx),
    .o_found (w_rdy_found)
  );

  // Capture a same-cycle broadcast for operands that are still pending at dispatch.
  always_comb begin
    w_d_v1  = disp_val1;
    w_d_q1b = disp_q1_busy;
    w_d_v2  = disp_val2;
    w_d_q2b = disp_q2_busy;
    if (disp_q1_busy) begin
      if (cdb_alu_valid && cdb_alu_src == disp_q1) begin
        w_d_v1  = cdb_alu_val;
        w_d_q1b = 1'b0;
      end else if (cdb_lsb_valid && cdb_lsb_src == disp_q1) begin
        w_d_v1  = cdb_lsb_val;
        w_d_q1b = 1'b0;
      end
    end
    if (disp_q2_busy) begin
      if (cdb_alu_valid && cdb_alu_src == disp_q2) begin
        w_d_v2  = cdb_alu_val;
        w_d_q2b = 1'b0;
      end else if (cdb_lsb_valid && cdb_lsb_src == disp_q2) begin
        w_d_v2  = cdb_lsb_val;
        w_d_q2b = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      alu_en      <= FALSE;
      alu_opt     <= '0;
      alu_val1    <= ZERO_WORD;
      alu_val2    <= ZERO_WORD;
      alu_imm     <= ZERO_WORD;
      alu_rob_idx <= '0;
    end else if (rdy) begin
      if (rob_flush) begin
        r_valid <= '0;
        alu_en  <= FALSE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_valid[i] && r_q1b[i]) begin
            if (cdb_alu_valid && cdb_alu_src == r_q1[i]) begin
              r_v1[i]  <= cdb_alu_val;
              r_q1b[i] <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_src == r_q1[i]) begin
              r_v1[i]  <= cdb_lsb_val;
              r_q1b[i] <= 1'b0;
            end
          end
          if (r_valid[i] && r_q2b[i]) begin
            if (cdb_alu_valid && cdb_alu_src == r_q2[i]) begin
              r_v2[i]  <= cdb_alu_val;
              r_q2b[i] <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_src == r_q2[i]) begin
              r_v2[i]  <= cdb_lsb_val;
              r_q2b[i] <= 1'b0;
            end
          end
        end

        if (w_rdy_found) begin
          alu_en              <= TRUE;
          alu_opt             <= r_opt[w_rdy_idx];
          alu_val1            <= r_v1[w_rdy_idx];
          alu_val2            <= r_v2[w_rdy_idx];
          alu_imm             <= r_imm[w_rdy_idx];
          alu_rob_idx         <= r_rob[w_rdy_idx];
          r_valid[w_rdy_idx]  <= 1'b0;
        end else begin
          alu_en <= FALSE;
        end

        // The free slot was invalid at cycle start, so it never collides with issue or wakeup.
        if (w_dispatch) begin
          r_valid[w_free_idx] <= 1'b1;
          r_opt[w_free_idx]   <= disp_opt;
          r_v1[w_free_idx]    <= w_d_v1;
          r_v2[w_free_idx]    <= w_d_v2;
          r_q1b[w_free_idx]   <= w_d_q1b;
          r_q2b[w_free_idx]   <= w_d_q2b;
          r_q1[w_free_idx]    <= disp_q1;
          r_q2[w_free_idx]    <= disp_q2;
          r_imm[w_free_idx]   <= disp_imm;
          r_rob[w_free_idx]   <= disp_rob_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios with literal
// expectations, then randomized traffic against a behavioural station model.
module tb_alu_rs_sched;
  import alu_rs_sched_pkg::*;

  localparam int RS = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_flush, disp_en;
  logic [5:0]  disp_opt;
  logic [31:0] disp_val1, disp_val2, disp_imm;
  logic        disp_q1_busy, disp_q2_busy;
  logic [3:0]  disp_q1, disp_q2, disp_rob_idx;
  logic        rs_full;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_src, cdb_lsb_src;
  logic [31:0] cdb_alu_val, cdb_lsb_val;
  logic        alu_en;
  logic [5:0]  alu_opt;
  logic [31:0] alu_val1, alu_val2, alu_imm;
  logic [3:0]  alu_rob_idx;

  int nCompared = 0;
  int nMismatch = 0;
  bit started = 0;

  alu_rs_sched #(.RS_SIZE(RS), .ROB_IDX_W(4), .OPT_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_flush(rob_flush),
    .disp_en(disp_en), .disp_opt(disp_opt),
    .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_src(cdb_alu_src), .cdb_lsb_src(cdb_lsb_src),
    .cdb_alu_val(cdb_alu_val), .cdb_lsb_val(cdb_lsb_val),
    .alu_en(alu_en), .alu_opt(alu_opt),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_rob_idx(alu_rob_idx)
  );

  always #5 clk = ~clk;

  // Behavioural model: the station is a bag of slots, outputs are the last issue.
  typedef struct {
    bit          v;
    logic [5:0]  opt;
    logic [31:0] v1, v2, imm;
    bit          b1, b2;
    logic [3:0]  q1, q2, rob;
  } ent_t;

  ent_t        m [RS];
  logic        mEn;
  logic [5:0]  mOpt;
  logic [31:0] mV1, mV2, mImm;
  logic [3:0]  mRob;

  function automatic bit cdbHit(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb_alu_valid && cdb_alu_src == tag) begin
      val = cdb_alu_val;
      return 1'b1;
    end
    if (cdb_lsb_valid && cdb_lsb_src == tag) begin
      val = cdb_lsb_val;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int modelCount();
    int c = 0;
    for (int i = 0; i < RS; i++) if (m[i].v) c++;
    return c;
  endfunction

  task automatic modelStep();
    int pick, free, cnt;
    logic [31:0] wv;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < RS; i++) m[i].v = 1'b0;
      mEn = 1'b0; mOpt = '0; mV1 = '0; mV2 = '0; mImm = '0; mRob = '0;
      started = 1'b1;
    end else if (rdy && rob_flush) begin
      for (int i = 0; i < RS; i++) m[i].v = 1'b0;
      mEn = 1'b0;
    end else if (rdy) begin
      cnt = modelCount();
      free = -1;
      pick = -1;
      for (int i = 0; i < RS; i++) begin
        if (!m[i].v && free < 0) free = i;
        if (m[i].v && !m[i].b1 && !m[i].b2 && pick < 0) pick = i;
      end
      for (int i = 0; i < RS; i++) begin
        if (m[i].v && m[i].b1 && cdbHit(m[i].q1, wv)) begin m[i].v1 = wv; m[i].b1 = 0; end
        if (m[i].v && m[i].b2 && cdbHit(m[i].q2, wv)) begin m[i].v2 = wv; m[i].b2 = 0; end
      end
      if (pick >= 0) begin
        mEn = 1'b1; mOpt = m[pick].opt; mV1 = m[pick].v1; mV2 = m[pick].v2;
        mImm = m[pick].imm; mRob = m[pick].rob;
        m[pick].v = 1'b0;
      end else begin
        mEn = 1'b0;
      end
      if (disp_en && cnt < RS) begin
        e.v = 1'b1; e.opt = disp_opt; e.imm = disp_imm; e.rob = disp_rob_idx;
        e.q1 = disp_q1; e.q2 = disp_q2;
        e.v1 = disp_val1; e.b1 = disp_q1_busy;
        e.v2 = disp_val2; e.b2 = disp_q2_busy;
        if (e.b1 && cdbHit(disp_q1, wv)) begin e.v1 = wv; e.b1 = 0; end
        if (e.b2 && cdbHit(disp_q2, wv)) begin e.v2 = wv; e.b2 = 0; end
        m[free] = e;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Outputs depend only on registered state, so the falling edge is a safe sample point.
  initial forever begin
    @(negedge clk);
    if (started) begin
      checkOutput("m_alu_en", 32'(alu_en), 32'(mEn));
      checkOutput("m_alu_opt", 32'(alu_opt), 32'(mOpt));
      checkOutput("m_alu_val1", alu_val1, mV1);
      checkOutput("m_alu_val2", alu_val2, mV2);
      checkOutput("m_alu_imm", alu_imm, mImm);
      checkOutput("m_alu_rob", 32'(alu_rob_idx), 32'(mRob));
      checkOutput("m_rs_full", 32'(rs_full), 32'(modelCount() == RS));
    end
  end

  task automatic clearPulses();
    disp_en = 0; rob_flush = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0;
    disp_q1_busy = 0; disp_q2_busy = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearPulses();
  endtask

  task automatic setDisp(input logic [5:0] opt, input logic [31:0] v1, input logic [31:0] v2,
                         input logic b1, input logic [3:0] q1, input logic b2, input logic [3:0] q2,
                         input logic [31:0] imm, input logic [3:0] rob);
    disp_en = 1; disp_opt = opt; disp_val1 = v1; disp_val2 = v2;
    disp_q1_busy = b1; disp_q1 = q1; disp_q2_busy = b2; disp_q2 = q2;
    disp_imm = imm; disp_rob_idx = rob;
  endtask

  initial begin
    rst = 1; rdy = 1;
    disp_opt = '0; disp_val1 = '0; disp_val2 = '0; disp_imm = '0;
    disp_q1 = '0; disp_q2 = '0; disp_rob_idx = '0;
    cdb_alu_src = '0; cdb_lsb_src = '0; cdb_alu_val = '0; cdb_lsb_val = '0;
    clearPulses();
    applyStimulus();
    applyStimulus();
    checkOutput("rst_alu_en", 32'(alu_en), 32'd0);
    checkOutput("rst_rs_full", 32'(rs_full), 32'd0);
    checkOutput("rst_alu_rob", 32'(alu_rob_idx), 32'd0);
    rst = 0;
    applyStimulus();

    // ADDI with ready operands issues two edges after dispatch.
    setDisp(OPT_ADDI, 32'd5, 32'd0, 0, 4'd0, 0, 4'd0, 32'd3, 4'd2);
    applyStimulus();
    checkOutput("t1_early_en", 32'(alu_en), 32'd0);
    checkOutput("t1_full", 32'(rs_full), 32'd0);
    applyStimulus();
    checkOutput("t1_en", 32'(alu_en), 32'd1);
    checkOutput("t1_opt", 32'(alu_opt), 32'(OPT_ADDI));
    checkOutput("t1_val1", alu_val1, 32'd5);
    checkOutput("t1_imm", alu_imm, 32'd3);
    checkOutput("t1_rob", 32'(alu_rob_idx), 32'd2);
    applyStimulus();
    checkOutput("t1_after_en", 32'(alu_en), 32'd0);

    // Operand 1 woken by the load-store broadcast.
    setDisp(OPT_ADD, 32'd0, 32'd1, 1, 4'd7, 0, 4'd0, 32'd0, 4'd3);
    applyStimulus();
    applyStimulus();
    checkOutput("t2_wait_en", 32'(alu_en), 32'd0);
    cdb_lsb_valid = 1; cdb_lsb_src = 4'd7; cdb_lsb_val = 32'h10;
    applyStimulus();
    checkOutput("t2_wake_en", 32'(alu_en), 32'd0);
    applyStimulus();
    checkOutput("t2_en", 32'(alu_en), 32'd1);
    checkOutput("t2_val1", alu_val1, 32'h10);
    checkOutput("t2_rob", 32'(alu_rob_idx), 32'd3);
    applyStimulus();

    // Dispatch bypass from the ALU broadcast.
    setDisp(OPT_SUB, 32'd1, 32'd0, 0, 4'd0, 1, 4'd4, 32'd0, 4'd5);
    cdb_alu_valid = 1; cdb_alu_src = 4'd4; cdb_alu_val = 32'd9;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_en", 32'(alu_en), 32'd1);
    checkOutput("t3_val2", alu_val2, 32'd9);
    checkOutput("t3_rob", 32'(alu_rob_idx), 32'd5);
    applyStimulus();

    // Fill the station, drop a ninth dispatch, then drain in index order.
    for (int i = 0; i < RS; i++) begin
      setDisp(OPT_ADD, 32'd0, 32'(i), 1, 4'd1, 0, 4'd0, 32'd0, 4'(i));
      applyStimulus();
    end
    checkOutput("t4_full", 32'(rs_full), 32'd1);
    setDisp(OPT_ADD, 32'd0, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd9);
    applyStimulus();
    checkOutput("t4_full_after_drop", 32'(rs_full), 32'd1);
    checkOutput("t4_drop_en", 32'(alu_en), 32'd0);
    cdb_lsb_valid = 1; cdb_lsb_src = 4'd1; cdb_lsb_val = 32'h100;
    applyStimulus();
    checkOutput("t4_wake_en", 32'(alu_en), 32'd0);
    for (int i = 0; i < RS; i++) begin
      applyStimulus();
      checkOutput($sformatf("t4_en_%0d", i), 32'(alu_en), 32'd1);
      checkOutput($sformatf("t4_rob_%0d", i), 32'(alu_rob_idx), 32'(i));
      checkOutput($sformatf("t4_val1_%0d", i), alu_val1, 32'h100);
      if (i == 0) checkOutput("t4_full_fall", 32'(rs_full), 32'd0);
    end
    applyStimulus();
    checkOutput("t4_drained_en", 32'(alu_en), 32'd0);

    // Flush while issuing with waiting entries present.
    for (int k = 0; k < 3; k++) begin
      setDisp(OPT_OR, 32'd0, 32'd0, 1, 4'd2, 0, 4'd0, 32'd0, 4'(10 + k));
      applyStimulus();
    end
    setDisp(OPT_AND, 32'd7, 32'd8, 0, 4'd0, 0, 4'd0, 32'd0, 4'd13);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_pre_en", 32'(alu_en), 32'd1);
    checkOutput("t5_pre_rob", 32'(alu_rob_idx), 32'd13);
    rob_flush = 1;
    setDisp(OPT_AND, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 32'd0, 4'd14);
    applyStimulus();
    checkOutput("t5_flush_en", 32'(alu_en), 32'd0);
    checkOutput("t5_flush_full", 32'(rs_full), 32'd0);
    cdb_lsb_valid = 1; cdb_lsb_src = 4'd2; cdb_lsb_val = 32'h55;
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput($sformatf("t5_empty_en_%0d", k), 32'(alu_en), 32'd0);
    end

    // Stall with a held issue and a pending ready entry.
    for (int k = 3; k <= 5; k++) begin
      setDisp(OPT_XOR, 32'(k), 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'(k));
      applyStimulus();
    end
    checkOutput("t6_pre_rob", 32'(alu_rob_idx), 32'd4);
    rdy = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput($sformatf("t6_hold_en_%0d", k), 32'(alu_en), 32'd1);
      checkOutput($sformatf("t6_hold_rob_%0d", k), 32'(alu_rob_idx), 32'd4);
    end
    rdy = 1;
    applyStimulus();
    checkOutput("t6_resume_en", 32'(alu_en), 32'd1);
    checkOutput("t6_resume_rob", 32'(alu_rob_idx), 32'd5);
    applyStimulus();
    checkOutput("t6_done_en", 32'(alu_en), 32'd0);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rob_flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        setDisp(6'($urandom_range(0, 9)), $urandom, $urandom,
                ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                $urandom, 4'($urandom_range(0, 15)));
      cdb_alu_valid = ($urandom_range(0, 2) == 0);
      cdb_alu_src = 4'($urandom_range(0, 7));
      cdb_alu_val = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 2) == 0);
      cdb_lsb_src = 4'($urandom_range(0, 7));
      cdb_lsb_val = $urandom;
      if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_src == cdb_lsb_src)
        cdb_lsb_src = cdb_lsb_src + 4'd1;
      applyStimulus();
    end

    rdy = 1;
    applyStimulus();
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/alu_rs_sched.md
# alu_rs_sched

Reservation-station scheduler that owns the integer ALU. It accepts dispatched ALU and branch µops from the decoder and holds them until both operands are available. It snoops the CDB to wake waiting operands, then issues one ready entry per cycle through a registered port into the ALU. It sits between the dispatch stage and the ALU and honours the global `rdy` stall and the ROB mispredict flush.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2)
- ROB_IDX_W, 4, ROB tag width
- OPT_W, 6, opcode width (matches shared opcode encoding)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- rob_flush  in  1  mispredict flush, clears station
- disp_en  in  1  dispatch request this cycle
- disp_opt  in  OPT_W  opcode
- disp_val1 / disp_val2  in  32  operand values (valid when matching q*_busy low)
- disp_q1_busy / disp_q2_busy  in  1  operand still pending
- disp_q1 / disp_q2  in  ROB_IDX_W  producer tag when pending
- disp_imm  in  32  immediate
- disp_rob_idx  in  ROB_IDX_W  destination tag
- rs_full  out  1  no free entry (combinational from entry valid bits)
- cdb_alu_valid / cdb_lsb_valid  in  1  broadcast valid (ALU / load-store)
- cdb_alu_src / cdb_lsb_src  in  ROB_IDX_W  broadcast tag
- cdb_alu_val / cdb_lsb_val  in  32  broadcast value
- alu_en  out  1  issue valid to ALU (registered)
- alu_opt  out  OPT_W  issued opcode (registered)
- alu_val1 / alu_val2 / alu_imm  out  32  issued operands (registered)
- alu_rob_idx  out  ROB_IDX_W  issued destination tag (registered)

## Operation
- Entry fields: valid, opt, v1, v2, q1_busy, q2_busy, q1, q2, imm, rob_idx.
- Entry ready = valid & !q1_busy & !q2_busy.
- Dispatch: when disp_en & !rs_full & !rob_flush & rdy, write the lowest-index free entry. The disp_en is silently dropped if rs_full.
- Dispatch bypass: if a disp operand is busy and its tag equals a same-cycle valid CDB tag, store the CDB value with busy=0.
- Wakeup: for each valid entry with q*_busy and a tag matching any valid CDB broadcast, load the value and clear busy. If both CDB ports match, the ALU port wins (the tags cannot legally coincide).
- Issue: each rdy cycle, select the lowest-index ready entry. Drive its fields onto the alu_* registers, set alu_en=1, and clear the entry's valid. If no entry is ready, alu_en=0 and the other alu_* hold their values.
- An entry woken this cycle is not ready until the next cycle.
- An entry freed by issue this cycle is not reusable by dispatch until the next cycle. rs_full is evaluated on start-of-cycle valid bits.
- Flush (rob_flush & rdy): clear all valid bits, alu_en←0, and drop any dispatch and issue in the same cycle.
- rdy low: no state changes, including the alu_* registers. A held alu_en=1 is executed once when rdy returns, because the ALU itself ignores it while rdy is low.
- Reset: all valid←0, alu_en←0, alu_opt←0, alu_val1/val2/imm←0, alu_rob_idx←0. rs_full=0 after reset. rst has priority over rob_flush and rdy.

## Timing
- Dispatch with ready operands at cycle N → entry valid at N+1, issued (alu_en=1) at N+2 if it is the lowest-index ready entry.
- CDB wakeup at N → entry ready at N+1 → alu_en at N+2.
- Throughput is 1 issue/cycle. The ALU result is on the CDB in the same cycle as alu_en (ALU is combinational), so a dependent entry wakes that cycle.
- Full/empty: rs_full is high exactly when all RS_SIZE valid bits are set. A dispatch and an issue in the same cycle when full results in the dispatch being dropped and the count becoming RS_SIZE-1.

## Structure
- Shared package (utils): OPT_* encodings, WORD_TP, ROB_IDX_TP, RS_SIZE default, TRUE/FALSE, ZERO_WORD.
- Sub-module `rs_pick`: parameterised find-first-set over an RS_SIZE-bit vector, outputting the index and a found flag. It is instantiated twice, once for free-slot selection and once for ready-entry selection.

## Test plan
- Reset then dispatch ADDI (opt=ADDI, val1=5, imm=3, both busy=0, rob_idx=2) → alu_en=1 two cycles later with alu_val1=5, alu_imm=3, alu_rob_idx=2; rs_full=0 throughout.
- Dispatch ADD with q1_busy, q1=7; two cycles later drive cdb_lsb_valid, src=7, val=0x10 → alu_en with alu_val1=0x10 two cycles after the CDB pulse, and not earlier.
- Dispatch with q2=4 busy in the same cycle as cdb_alu_valid, src=4, val=9 → entry stored ready with v2=9, issued N+2.
- Fill 8 entries all waiting on tag 1 → rs_full=1, and a 9th disp_en is dropped. Broadcast tag 1 → entries issue in index order 0..7 on 8 consecutive cycles, and rs_full falls the cycle after the first issue.
- With 3 valid entries and alu_en high, pulse rob_flush → all entries cleared, alu_en=0 next cycle, and the same-cycle dispatch is absent.
- Hold rdy=0 for 5 cycles with ready entries and alu_en=1 → outputs are frozen and no entry is lost or duplicated; after rdy=1 the issue order resumes unchanged.
